// File: rtl/instruction_encoder.sv
// instruction_encoder: packs RISC-V style instruction fields (R/I/S/B/U/J)
// into a 32-bit word and buffers the results in a small output FIFO.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised, the payload is held until that edge.
// in_ready depends only on FIFO occupancy, never on out_ready.
//
// Optional feature: define INSTRUCTION_ENCODER_CHECK_EN to store a per-entry
// range-check error bit. Without it err is tied low and fields truncate.
module instruction_encoder #(
  parameter int OUT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err,
  output logic [15:0] enc_count
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [31:0]   mem [OUT_DEPTH];
  logic [31:0]   last_instr;
  logic [31:0]   enc_word;
  logic          push;
  logic          pop;

  assign in_ready  = (count != CW'(OUT_DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head of the FIFO when occupied; otherwise the last word handed out,
  // so instr stays stable while the buffer is empty.
  assign instr = out_valid ? mem[rptr] : last_instr;

  // Field packing for each format; illegal formats encode to zero.
  always_comb begin
    enc_word = 32'h0000_0000;
    case (fmt)
      FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1],
                         imm[11], opcode};
      FMT_U: enc_word = {imm[31:12], rd, opcode};
      FMT_J: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc_word = 32'h0000_0000;
    endcase
  end

  // Pointers, occupancy, held output word and accepted-bundle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      last_instr <= 32'h0000_0000;
      enc_count  <= 16'h0000;
    end else begin
      if (push) begin
        wptr      <= wptr + AW'(1);
        enc_count <= enc_count + 16'h0001;
      end
      if (pop) begin
        rptr       <= rptr + AW'(1);
        last_instr <= mem[rptr];
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= enc_word;
    end
  end

`ifdef INSTRUCTION_ENCODER_CHECK_EN
  logic err_mem [OUT_DEPTH];
  logic enc_err;

  // Range check: immediate must fit the format's field after sign extension.
  always_comb begin
    enc_err = 1'b0;
    case (fmt)
      FMT_R: enc_err = 1'b0;
      FMT_I, FMT_S: enc_err = (imm[31:11] != {21{imm[11]}});
      FMT_B: enc_err = (imm[31:12] != {20{imm[12]}}) | imm[0];
      FMT_U: enc_err = (imm[11:0] != 12'h000);
      FMT_J: enc_err = (imm[31:20] != {12{imm[20]}}) | imm[0];
      default: enc_err = 1'b1;
    endcase
  end

  // Error bit travels alongside its encoded word.
  always_ff @(posedge clk) begin
    if (push) begin
      err_mem[wptr] <= enc_err;
    end
  end

  assign err = out_valid & err_mem[rptr];
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed testbench for instruction_encoder (default OUT_DEPTH = 2).
// Expected err values follow INSTRUCTION_ENCODER_CHECK_EN when defined.
module tb_instruction_encoder;

  localparam int DEPTH = 2;

`ifdef INSTRUCTION_ENCODER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic        err;
  logic [15:0] enc_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  instruction_encoder #(.OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .err(err),
    .enc_count(enc_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op,
                            input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
  endtask

  // driver: offer the current fields for one cycle (FIFO assumed not full)
  task automatic send();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // send one bundle, check head word and err, then pop it
  task automatic enc_case(input string tag, input logic [31:0] exp_w,
                          input logic exp_e);
    send();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_instr"}, instr, exp_w);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_e});
    pop_one();
  endtask

  initial begin
    int accepted;
    logic [31:0] w;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

    do_reset();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_enc_count", {16'd0, enc_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // I format
    set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    enc_case("i_fmt", 32'h0050_0093, 1'b0);
    check("empty_valid", {31'd0, out_valid}, 32'd0);
    check("empty_hold_instr", instr, 32'h0050_0093);

    // R format; funct7 nonzero-free, imm garbage must be ignored
    set_fields(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);
    enc_case("r_fmt", 32'h0020_81B3, 1'b0);

    // S format: sw x5,12(x2)
    set_fields(3'd2, 7'h23, 5'd31, 5'd2, 5'd5, 3'd2, 7'h7F, 32'd12);
    enc_case("s_fmt", 32'h0051_2623, 1'b0);

    // B format, imm = -4
    set_fields(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    enc_case("b_fmt", 32'hFE20_8EE3, 1'b0);

    // U format
    set_fields(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    enc_case("u_fmt", 32'h1234_52B7, 1'b0);

    // J format
    set_fields(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    enc_case("j_fmt", 32'h0080_00EF, 1'b0);

    // illegal fmt encodes to zero
    set_fields(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'd1);
    enc_case("fmt7", 32'h0, CHK);

    // I format immediate out of range: truncated, flagged when checked
    set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    enc_case("i_range", 32'h8000_0093, CHK);

    // U format with low bits set: truncated, flagged when checked
    set_fields(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    enc_case("u_range", 32'h1234_52B7, CHK);

    check("enc_count_9", {16'd0, enc_count}, 32'd9);

    // backpressure: offer DEPTH+1 bundles with out_ready low
    do_reset();
    accepted = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_fields(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'(i + 1));
      w = {12'(i + 1), 5'd3, 3'd0, 5'd2, 7'h13};
      if (in_ready) begin
        accepted++;
        exp_q.push_back(w);
      end
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(accepted), 32'(DEPTH));
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_enc_count", {16'd0, enc_count}, 32'(DEPTH));

    // drain in order; bounded by a cycle budget
    out_ready = 1'b1;
    for (int n = 0; n < 4 * DEPTH && exp_q.size() > 0; n++) begin
      if (out_valid) begin
        w = exp_q.pop_front();
        check("bp_drain_order", instr, w);
      end
      tick();
    end
    out_ready = 1'b0;
    check("bp_drain_done", 32'(exp_q.size()), 32'd0);
    check("bp_empty", {31'd0, out_valid}, 32'd0);
    check("bp_enc_count_after", {16'd0, enc_count}, 32'(DEPTH));

    // simultaneous push and pop with one entry buffered
    set_fields(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hAAAA_A000);
    send();
    set_fields(3'd4, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h5555_5000);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pp_valid", {31'd0, out_valid}, 32'd1);
    check("pp_instr", instr, 32'h5555_5137);
    check("pp_in_ready", {31'd0, in_ready}, 32'd1);
    pop_one();
    check("pp_empty", {31'd0, out_valid}, 32'd0);

    // reset mid-operation discards data and ignores the concurrent bundle
    send();
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_count", {16'd0, enc_count}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
